// File: rtl/wb_regfile_pkg.sv
// -----------------------------------------------------------------------------
// legv8_pkg
// Shared LEGv8 core definitions: datapath width, register count, the XZR
// index, and the register-index and data-word types used by the pipeline.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package legv8_pkg;

  localparam int DATA_W   = 64;
  localparam int REG_N    = 32;
  localparam int ZERO_REG = 31;

  typedef logic [4:0]        reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

`default_nettype wire

// File: rtl/wb_regfile_if.sv
// -----------------------------------------------------------------------------
// wb_regfile_if
// MEM/WB inputs, ID-stage read ports and forwarding/debug outputs of the
// writeback stage. The master side is the pipeline; the slave side is
// wb_regfile. dbg_cnt_load/dbg_cnt_value preload the retired-write counter
// for debug.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface wb_regfile_if #(
  parameter int DATA_W = legv8_pkg::DATA_W
);
  import legv8_pkg::*;

  // MEM/WB pipeline register outputs
  logic [DATA_W-1:0] Read_data;
  logic [DATA_W-1:0] Alu_result;
  reg_idx_t          Write_reg;
  logic              RegWrite;
  logic              MemtoReg;

  // ID-stage read ports
  reg_idx_t          read_reg1;
  reg_idx_t          read_reg2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;

  // Writeback, forwarding and debug
  logic [DATA_W-1:0] wb_data;
  logic              fwd_valid;
  reg_idx_t          fwd_reg;
  logic [DATA_W-1:0] fwd_data;
  logic [31:0]       wb_count;
  logic              dbg_cnt_load;
  logic [31:0]       dbg_cnt_value;

  modport master (
    output Read_data, Alu_result, Write_reg, RegWrite, MemtoReg,
    output read_reg1, read_reg2, dbg_cnt_load, dbg_cnt_value,
    input  read_data1, read_data2, wb_data,
    input  fwd_valid, fwd_reg, fwd_data, wb_count
  );

  modport slave (
    input  Read_data, Alu_result, Write_reg, RegWrite, MemtoReg,
    input  read_reg1, read_reg2, dbg_cnt_load, dbg_cnt_value,
    output read_data1, read_data2, wb_data,
    output fwd_valid, fwd_reg, fwd_data, wb_count
  );

endinterface

`default_nettype wire

// File: rtl/wb_regfile_regfile.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
// Architectural register array: one write port, two combinational read
// ports. XZR always reads as zero; a read of the register being written in
// the same cycle returns the incoming write data.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module regfile_2r1w
  import legv8_pkg::*;
#(
  parameter int DATA_W   = legv8_pkg::DATA_W,
  parameter int REG_N    = legv8_pkg::REG_N,
  parameter int ZERO_REG = legv8_pkg::ZERO_REG
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we,       // already excludes XZR
  input  reg_idx_t          waddr,
  input  logic [DATA_W-1:0] wdata,
  input  reg_idx_t          raddr1,
  input  reg_idx_t          raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam reg_idx_t XZR = reg_idx_t'(ZERO_REG);

  logic [DATA_W-1:0] regs [REG_N];

  // Array update: cleared on reset, otherwise commit the gated write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_N; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Read port A: XZR first, then same-cycle bypass, then the array.
  always_comb begin
    rdata1 = regs[raddr1];
    if (raddr1 == XZR) begin
      rdata1 = '0;
    end else if (we && (waddr == raddr1)) begin
      rdata1 = wdata;
    end
  end

  // Read port B: same priority as port A.
  always_comb begin
    rdata2 = regs[raddr2];
    if (raddr2 == XZR) begin
      rdata2 = '0;
    end else if (we && (waddr == raddr2)) begin
      rdata2 = wdata;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
// LEGv8 writeback stage: selects memory data or ALU result, commits it to
// the register file, registers the last committed write for the forwarding
// unit and counts retired (non-XZR) writes.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module wb_regfile
  import legv8_pkg::*;
#(
  parameter int DATA_W   = legv8_pkg::DATA_W,
  parameter int REG_N    = legv8_pkg::REG_N,
  parameter int ZERO_REG = legv8_pkg::ZERO_REG
) (
  input  logic         clock,
  input  logic         reset_n,
  wb_regfile_if.slave  bus
);

  localparam reg_idx_t XZR = reg_idx_t'(ZERO_REG);

  logic [DATA_W-1:0] wb_data;
  logic              we;
  logic              fwd_valid;
  reg_idx_t          fwd_reg;
  logic [DATA_W-1:0] fwd_data;
  logic [31:0]       wb_count;

  // Writeback select and commit qualifier (writes to XZR are dropped).
  always_comb begin
    wb_data = bus.MemtoReg ? bus.Read_data : bus.Alu_result;
    we      = bus.RegWrite && (bus.Write_reg != XZR);
  end

  regfile_2r1w #(
    .DATA_W   (DATA_W),
    .REG_N    (REG_N),
    .ZERO_REG (ZERO_REG)
  ) u_regfile (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (we),
    .waddr   (bus.Write_reg),
    .wdata   (wb_data),
    .raddr1  (bus.read_reg1),
    .raddr2  (bus.read_reg2),
    .rdata1  (bus.read_data1),
    .rdata2  (bus.read_data2)
  );

  // Forwarding register: valid pulses per commit, reg/data hold between commits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fwd_valid <= 1'b0;
      fwd_reg   <= '0;
      fwd_data  <= '0;
    end else begin
      fwd_valid <= we;
      if (we) begin
        fwd_reg  <= bus.Write_reg;
        fwd_data <= wb_data;
      end
    end
  end

  // Retired-write counter; a debug preload takes precedence over counting.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_count <= '0;
    end else if (bus.dbg_cnt_load) begin
      wb_count <= bus.dbg_cnt_value;
    end else if (we) begin
      wb_count <= wb_count + 32'd1;
    end
  end

  assign bus.wb_data   = wb_data;
  assign bus.fwd_valid = fwd_valid;
  assign bus.fwd_reg   = fwd_reg;
  assign bus.fwd_data  = fwd_data;
  assign bus.wb_count  = wb_count;

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
// Scoreboard bench for wb_regfile: the driver computes expected outputs from
// an array model of the architectural registers and queues them; a monitor
// on the falling edge pops and compares.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_wb_regfile;
  import legv8_pkg::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Reference state: value each register holds after the most recent edge.
  logic [63:0] m_regs [32];
  logic        m_fv;
  logic [4:0]  m_fr;
  logic [63:0] m_fd;
  logic [31:0] m_cnt;

  typedef struct packed {
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] wbd;
    logic        fv;
    logic [4:0]  fr;
    logic [63:0] fd;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_fv  = 1'b0;
    m_fr  = '0;
    m_fd  = '0;
    m_cnt = '0;
  endfunction

  // Architectural read: XZR is zero, a register being written this cycle
  // shows its new value, anything else shows the stored value.
  function automatic logic [63:0] model_read(input logic [4:0] r, input logic commit,
                                             input logic [4:0] wr, input logic [63:0] v);
    if (r == 5'd31) return 64'd0;
    if (commit && r == wr) return v;
    return m_regs[r];
  endfunction

  // One pipeline cycle: drive MEM/WB + read addresses, queue the expected
  // outputs for this cycle, then advance the model past the next edge.
  task automatic step(input logic rw, input logic mtr, input logic [4:0] wr,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic [63:0] rd, input logic [63:0] alu,
                      input logic ld, input logic [31:0] ldv);
    exp_t        e;
    logic [63:0] v;
    logic        commit;
    @(posedge clock);
    #1;
    bus.RegWrite      = rw;
    bus.MemtoReg      = mtr;
    bus.Write_reg     = wr;
    bus.read_reg1     = r1;
    bus.read_reg2     = r2;
    bus.Read_data     = rd;
    bus.Alu_result    = alu;
    bus.dbg_cnt_load  = ld;
    bus.dbg_cnt_value = ldv;
    v      = mtr ? rd : alu;
    commit = rw && (wr != 5'd31);
    e.rd1  = model_read(r1, commit, wr, v);
    e.rd2  = model_read(r2, commit, wr, v);
    e.wbd  = v;
    e.fv   = m_fv;
    e.fr   = m_fr;
    e.fd   = m_fd;
    e.cnt  = m_cnt;
    exp_q.push_back(e);
    if (commit) begin
      m_regs[wr] = v;
      m_fr       = wr;
      m_fd       = v;
    end
    m_fv = commit;
    if (ld) m_cnt = ldv;
    else if (commit) m_cnt = m_cnt + 32'd1;
  endtask

  task automatic idle_read(input logic [4:0] r1, input logic [4:0] r2);
    step(1'b0, 1'b0, 5'd0, r1, r2, 64'd0, 64'd0, 1'b0, 32'd0);
  endtask

  // Monitor: compare every cycle the DUT is out of reset and something is queued.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("read_data1", bus.read_data1, e.rd1);
      check("read_data2", bus.read_data2, e.rd2);
      check("wb_data",    bus.wb_data,    e.wbd);
      check("fwd_valid",  {63'd0, bus.fwd_valid}, {63'd0, e.fv});
      check("fwd_reg",    {59'd0, bus.fwd_reg},   {59'd0, e.fr});
      check("fwd_data",   bus.fwd_data,   e.fd);
      check("wb_count",   {32'd0, bus.wb_count},  {32'd0, e.cnt});
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_read_data1"}, bus.read_data1, 64'd0);
    check({tag, "_read_data2"}, bus.read_data2, 64'd0);
    check({tag, "_fwd_valid"},  {63'd0, bus.fwd_valid}, 64'd0);
    check({tag, "_fwd_reg"},    {59'd0, bus.fwd_reg},   64'd0);
    check({tag, "_fwd_data"},   bus.fwd_data, 64'd0);
    check({tag, "_wb_count"},   {32'd0, bus.wb_count},  64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] wr;
    model_reset();
    bus.RegWrite      = 1'b0;
    bus.MemtoReg      = 1'b0;
    bus.Write_reg     = '0;
    bus.read_reg1     = 5'd5;
    bus.read_reg2     = 5'd7;
    bus.Read_data     = '0;
    bus.Alu_result    = '0;
    bus.dbg_cnt_load  = 1'b0;
    bus.dbg_cnt_value = '0;

    // Power-on reset
    #2;
    check_reset_outputs("por");
    #10 reset_n = 1'b1;

    // Basic write with bypass, then readback and forwarding
    step(1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 64'd0, 64'h1234, 1'b0, 32'd0);
    idle_read(5'd5, 5'd5);
    // Memory select to XZR: discarded, no forward, no count
    step(1'b1, 1'b1, 5'd31, 5'd31, 5'd5, 64'hDEAD_BEEF, 64'd0, 1'b0, 32'd0);
    idle_read(5'd31, 5'd31);
    // Dual-port read of the register being written
    step(1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 64'd0, 64'hAA, 1'b0, 32'd0);
    step(1'b1, 1'b0, 5'd7, 5'd7, 5'd7, 64'd0, 64'hBB, 1'b0, 32'd0);
    idle_read(5'd7, 5'd7);
    // Bubble: no write, forwarding reg/data hold
    step(1'b0, 1'b0, 5'd3, 5'd3, 5'd7, 64'd0, 64'hFF, 1'b0, 32'd0);
    idle_read(5'd3, 5'd3);
    // Back-to-back writes to one register
    step(1'b1, 1'b1, 5'd9, 5'd9, 5'd9, 64'h111, 64'd0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 5'd9, 5'd9, 5'd1, 64'd0, 64'h222, 1'b0, 32'd0);
    idle_read(5'd9, 5'd1);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      wr = 5'($urandom_range(0, 31));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), wr,
           ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)),
           ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)),
           {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 32'd0);
    end

    // Reset asserted during a write that spans an edge: the write is lost
    step(1'b1, 1'b0, 5'd5, 5'd5, 5'd7, 64'd0, 64'h5555, 1'b0, 32'd0);
    @(posedge clock);
    #1;
    bus.RegWrite   = 1'b1;
    bus.MemtoReg   = 1'b0;
    bus.Write_reg  = 5'd4;
    bus.Alu_result = 64'h4444;
    bus.read_reg1  = 5'd5;
    bus.read_reg2  = 5'd9;
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clock);
    #2;
    check_reset_outputs("held_reset");
    bus.RegWrite = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;

    // Every register reads zero after reset
    for (int i = 0; i < 32; i++) begin
      idle_read(5'(i), 5'(31 - i));
    end

    // Counter wrap via debug preload
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 1'b1, 32'hFFFF_FFFE);
    step(1'b1, 1'b0, 5'd2, 5'd2, 5'd0, 64'd0, 64'h77, 1'b0, 32'd0);
    step(1'b1, 1'b0, 5'd3, 5'd2, 5'd3, 64'd0, 64'h88, 1'b0, 32'd0);
    step(1'b1, 1'b0, 5'd31, 5'd2, 5'd3, 64'd0, 64'h99, 1'b0, 32'd0);
    idle_read(5'd2, 5'd3);

    @(negedge clock);
    #1;
    check("queue_drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
